// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the nibble-serial 16x16 multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NIBBLES = 4;
    localparam int PP_W    = 8;
    localparam int ACC_W   = 32;

    // Place an 8-bit partial product at its weight: idx[1:0] is the a nibble,
    // idx[3:2] the b nibble, so the shift is 4*(i+j) with a maximum of 24.
    function automatic logic [ACC_W-1:0] shift_pp(input logic [PP_W-1:0] pp,
                                                   input logic [3:0]      idx);
        logic [4:0] shamt;
        shamt = {1'b0, idx[1:0], 2'b00} + {1'b0, idx[3:2], 2'b00};
        return {{(ACC_W-PP_W){1'b0}}, pp} << shamt;
    endfunction

endpackage

// File: rtl/multiplier_4_bit.sv
// rtl/multiplier_4_bit.sv - combinational 4x4 unsigned multiplier core
// Ports:
//   a_i [3:0]  multiplicand nibble
//   b_i [3:0]  multiplier nibble
//   p_o [7:0]  product a_i*b_i
module multiplier_4_bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = {4'b0000, a_i} * {4'b0000, b_i};

endmodule

// File: rtl/mult16_seq_ctrl.sv
// rtl/mult16_seq_ctrl.sv - 16x16 unsigned multiplier sequenced over one 4x4 core
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       16-bit unsigned operands
//   out_valid  product p valid (DONE)
//   out_ready  consumer accepts p
//   p          32-bit product, held stable while out_valid && !out_ready
//   busy       high while partial products are being accumulated
// Parameter:
//   PP_REG     1 = register the core output before accumulation (+1 cycle)
module mult16_seq_ctrl
    import mult_pkg::*;
#(
    parameter int PP_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy
);

    state_e              state_q;
    logic [15:0]         a_q;
    logic [15:0]         b_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_dly_q;
    logic [PP_W-1:0]     pp_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    p_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [3:0]          a_nib;
    logic [3:0]          b_nib;
    logic [PP_W-1:0]     core_pp;
    logic [PP_W-1:0]     add_pp;
    logic [3:0]          add_idx;
    logic [ACC_W-1:0]    acc_d;

    // i = cnt[1:0] walks the a nibbles fastest, j = cnt[3:2] the b nibbles.
    assign a_nib = a_q[{cnt_q[1:0], 2'b00} +: 4];
    assign b_nib = b_q[{cnt_q[3:2], 2'b00} +: 4];

    multiplier_4_bit u_core (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (core_pp)
    );

    // With the pp register the product being added belongs to the previous
    // count, so its weight comes from the delayed counter.
    assign add_pp  = (PP_REG != 0) ? pp_q      : core_pp;
    assign add_idx = (PP_REG != 0) ? cnt_dly_q : cnt_q;
    assign acc_d   = acc_q + shift_pp(add_pp, add_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            cnt_dly_q   <= '0;
            pp_q        <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        cnt_dly_q  <= '0;
                        // Empty pp register makes the first RUN cycle add zero.
                        pp_q       <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q     <= acc_d;
                    cnt_q     <= cnt_q + 4'd1;
                    cnt_dly_q <= cnt_q;
                    pp_q      <= core_pp;
                    if (cnt_q == 4'hF) begin
                        if (PP_REG != 0) begin
                            state_q <= FLUSH;
                        end else begin
                            p_q         <= acc_d;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end
                    end
                end
                FLUSH: begin
                    acc_q       <= acc_d;
                    p_q         <= acc_d;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= DONE;
                end
                DONE: begin
                    // Operands offered in this cycle are left for the next IDLE cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// tb/tb_mult16_seq_ctrl.sv - self-checking bench for mult16_seq_ctrl (PP_REG=0 and PP_REG=1)
module tb_mult16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] a         [2];
    logic [15:0] b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] p         [2];
    logic        busy      [2];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mult16_seq_ctrl #(.PP_REG(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .a         (a[0]),
        .b         (b[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .p         (p[0]),
        .busy      (busy[0])
    );

    mult16_seq_ctrl #(.PP_REG(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .a         (a[1]),
        .b         (b[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .p         (p[1]),
        .busy      (busy[1])
    );

    // Reference: the product is plain arithmetic; latency is 16 core cycles
    // plus one when the partial product is registered.
    function automatic logic [31:0] model_p(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    function automatic int model_lat(input int s);
        return 16 + s;
    endfunction

    // Offer operands and return #1 after the accept edge.
    task automatic accept(input int s, input logic [15:0] x, input logic [15:0] y, input bit keep);
        int k;
        @(negedge clk);
        a[s] = x;
        b[s] = y;
        in_valid[s] = 1'b1;
        k = 0;
        while (!in_ready[s] && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (in_ready[s] !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout[%0d]: in_ready=%b expected 1", s, in_ready[s]);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, output int lat, output int busy_n);
        lat = -1;
        busy_n = (busy[s] === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[s] === 1'b1) begin
                lat = k;
                break;
            end
            if (busy[s] === 1'b1) busy_n++;
        end
    endtask

    task automatic release_out(input int s);
        @(negedge clk);
        out_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[s] !== 1'b0) begin
            fails++;
            $display("FAIL release_out_valid[%0d]: got %b expected 0", s, out_valid[s]);
        end
        checks++;
        if (in_ready[s] !== 1'b1) begin
            fails++;
            $display("FAIL release_in_ready[%0d]: got %b expected 1", s, in_ready[s]);
        end
        @(negedge clk);
        out_ready[s] = 1'b0;
    endtask

    task automatic run_op(input int s, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp_p, input bit chk_busy, input string name);
        int lat, busy_n;
        accept(s, x, y, 1'b0);
        wait_done(s, lat, busy_n);
        checks++;
        if (lat != model_lat(s)) begin
            fails++;
            $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, s, lat, model_lat(s));
        end
        checks++;
        if (p[s] !== exp_p) begin
            fails++;
            $display("FAIL %s_p[%0d]: got %h expected %h", name, s, p[s], exp_p);
        end
        if (chk_busy) begin
            checks++;
            if (busy_n != model_lat(s)) begin
                fails++;
                $display("FAIL %s_busy_cycles[%0d]: got %0d expected %0d", name, s, busy_n, model_lat(s));
            end
        end
        release_out(s);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 || busy[s] !== 1'b0 || p[s] !== 32'h0) begin
                fails++;
                $display("FAIL reset_values[%0d]: in_ready=%b out_valid=%b busy=%b p=%h expected 1 0 0 00000000",
                         s, in_ready[s], out_valid[s], busy[s], p[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(0, 16'h1234, 16'h5678, 32'h06260060, 1'b0, "dir_1234x5678");
        run_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, "dir_ffff_pp1");
        run_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, "dir_ffff_pp0");
        run_op(0, 16'h0000, 16'hABCD, 32'h00000000, 1'b1, "dir_zero");
    endtask

    task automatic test_backpressure(input int s);
        int lat, busy_n;
        accept(s, 16'h00FF, 16'h0100, 1'b0);
        wait_done(s, lat, busy_n);
        checks++;
        if (lat != model_lat(s)) begin
            fails++;
            $display("FAIL bp_latency[%0d]: got %0d expected %0d", s, lat, model_lat(s));
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid[s] !== 1'b1 || p[s] !== 32'h0000FF00 || in_ready[s] !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d] cycle %0d: out_valid=%b p=%h in_ready=%b expected 1 0000ff00 0",
                         s, k, out_valid[s], p[s], in_ready[s]);
            end
            @(posedge clk);
            #1;
        end
        release_out(s);
    endtask

    task automatic test_reset_mid();
        bit seen;
        accept(0, 16'h1234, 16'h5678, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || p[0] !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_values: in_ready=%b out_valid=%b busy=%b p=%h expected 1 0 0 00000000",
                     in_ready[0], out_valid[0], busy[0], p[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_no_out_valid: out_valid seen=%b expected 0", seen);
        end
        run_op(0, 16'h0003, 16'h0005, 32'h0000000F, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 6; n++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                if (n == 0) x = 16'hFFFF;
                run_op(s, x, y, model_p(x, y), 1'b0, "random");
            end
        end
    endtask

    task automatic test_back_to_back(input int s);
        int          nv;
        int          t[2];
        logic [31:0] pv[2];
        int          lat;
        lat = model_lat(s);
        nv = 0;
        t[0] = -1; t[1] = -1; pv[0] = '0; pv[1] = '0;
        out_ready[s] = 1'b1;
        accept(s, 16'hBEEF, 16'h1357, 1'b1);
        // Junk operands while busy; must not be sampled.
        a[s] = 16'hDEAD;
        b[s] = 16'hFACE;
        for (int k = 1; k <= 2 * lat + 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[s] === 1'b1 && nv < 2) begin
                t[nv] = k;
                pv[nv] = p[s];
                nv++;
            end
            if (k == 10) begin
                a[s] = 16'h8001;
                b[s] = 16'h7FFE;
            end
            if (k == lat + 2) in_valid[s] = 1'b0;
        end
        in_valid[s] = 1'b0;
        checks++;
        if (t[0] != lat || pv[0] !== model_p(16'hBEEF, 16'h1357)) begin
            fails++;
            $display("FAIL b2b_first[%0d]: cycle %0d p=%h expected cycle %0d p=%h",
                     s, t[0], pv[0], lat, model_p(16'hBEEF, 16'h1357));
        end
        checks++;
        if (t[1] != 2 * lat + 2 || pv[1] !== model_p(16'h8001, 16'h7FFE)) begin
            fails++;
            $display("FAIL b2b_second[%0d]: cycle %0d p=%h expected cycle %0d p=%h",
                     s, t[1], pv[1], 2 * lat + 2, model_p(16'h8001, 16'h7FFE));
        end
        @(negedge clk);
        out_ready[s] = 1'b0;
        checks++;
        if (in_ready[s] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle[%0d]: in_ready=%b expected 1", s, in_ready[s]);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b0;
            a[s]         = '0;
            b[s]         = '0;
        end
        test_reset();
        test_directed();
        test_backpressure(0);
        test_backpressure(1);
        test_reset_mid();
        test_random();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
